// File: rtl/imem_program_loader.sv
// Streams a length-prefixed, XOR-checked program image into IMEM as little-endian
// 32-bit words and keeps the core in reset until a complete, valid image is loaded.
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        core_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // LEN0  | expecting low byte of word count
  // LEN1  | expecting high byte of word count
  // DATA  | receiving 4*N image bytes
  // CSUM  | expecting XOR checksum byte
  // DONE  | image valid, core released
  // ERROR | length too large or checksum mismatch
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] n_q, n_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [7:0]  xor_q, xor_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        core_rst_q, core_rst_d;

  logic        busy;
  logic        accept;
  logic [15:0] len_in;

  assign busy   = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                  (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept = busy && in_valid_i;
  assign len_in = {in_data_i, len_lo_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_lo_q   <= 8'h00;
      n_q        <= 16'h0000;
      idx_q      <= 16'h0000;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'h00_0000;
      xor_q      <= 8'h00;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'h0000_0000;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      xor_q      <= xor_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      core_rst_q <= core_rst_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    n_d        = n_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    xor_d      = xor_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d    = S_LEN0;
          xor_d      = 8'h00;
          byte_cnt_d = 2'd0;
          idx_d      = 16'h0000;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_lo_d = in_data_i;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          n_d = len_in;
          if ({1'b0, len_in} > MAX_N) begin
            state_d = S_ERROR;
          end else if (len_in == 16'h0000) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ in_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Fourth byte completes the word; the write overlaps the next byte's acceptance.
            we_d    = 1'b1;
            wdata_d = {in_data_i, shift_q};
            addr_d  = BASE_ADDR + {14'b0, idx_q, 2'b00};
            idx_d   = idx_q + 16'd1;
            if (idx_q == n_q - 16'd1) begin
              state_d = S_CSUM;
            end
          end else begin
            shift_d = {in_data_i, shift_q[23:8]};
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data_i == xor_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so the release lines up with DONE and re-asserts as DONE is left.
    core_rst_d = (state_d != S_DONE);
  end

  assign in_ready_o   = busy;
  assign busy_o       = busy;
  assign done_o       = (state_q == S_DONE);
  assign error_o      = (state_q == S_ERROR);
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign core_rst_o   = core_rst_q;

endmodule
